// File: rtl/multi_cycle_cpu_pkg.sv
// Shared opcode/funct constants, FSM state encoding and control-word types
// for the multi-cycle MIPS-subset core.
package multi_cycle_cpu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_JUMP, PC_ALUOUT, PC_REG_A} pc_src_e;
  typedef enum logic [1:0] {OPB_REG, OPB_SEXT, OPB_ZEXT, OPB_LUI} opb_sel_e;
  typedef enum logic [1:0] {WA_RD, WA_RT, WA_RA} waddr_sel_e;
  typedef enum logic [1:0] {WD_ALUOUT, WD_MDR, WD_PC} wdata_sel_e;

  // One control word per cycle; all-zero means "do nothing".
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_aluout;  // 0: mem_addr=PC, 1: mem_addr=ALUOut
    logic       ir_we;
    logic       pc_we;
    pc_src_e    pc_src;
    logic       ab_we;
    logic       aluout_we;
    logic       aluout_alu;   // 0: branch target, 1: ALU result
    logic       mdr_we;
    logic       rf_we;
    waddr_sel_e waddr_sel;
    wdata_sel_e wdata_sel;
    alu_op_e    alu_op;
    opb_sel_e   opb_sel;
    logic       retire;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR};
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e funct_alu_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; shifts take their distance from shamt and operate on b.
module alu
  import multi_cycle_cpu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  alu_op_e             op_i,
  input  logic [DATA_LEN-1:0] a_i,
  input  logic [DATA_LEN-1:0] b_i,
  input  logic [4:0]          shamt_i,
  output logic [DATA_LEN-1:0] y_o
);

  // Operation select
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_OR:    y_o = a_i | b_i;
      ALU_SLT:   y_o = DATA_LEN'($signed(a_i) < $signed(b_i));
      ALU_SLL:   y_o = b_i << shamt_i;
      ALU_SRL:   y_o = b_i >> shamt_i;
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_cpu_ctrl.sv
// Control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT and the per-state control word.
// Memory handshake: a request (mem_req, plus mem_we/mem_addr/mem_wdata) is
// held unchanged until an edge where mem_req=1 and mem_ready=1; that edge
// completes the access and is the only edge that may leave FETCH or MEM.
module multi_cycle_cpu_ctrl
  import multi_cycle_cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  input  logic       a_eq_b_i,
  output ctrl_t      ctrl_o,
  output state_e     state_o
);

  state_e state_q, state_d;

  // State register; reset overrides everything including HALT
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control-word decode
  always_comb begin
    ctrl_o  = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        if (mem_ready_i) begin
          ctrl_o.ir_we  = 1'b1;
          ctrl_o.pc_we  = 1'b1;
          ctrl_o.pc_src = PC_PLUS4;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        // Operand latch and branch-target precompute happen unconditionally
        ctrl_o.ab_we      = 1'b1;
        ctrl_o.aluout_we  = 1'b1;
        ctrl_o.aluout_alu = 1'b0;
        if (!is_legal(opcode_i, funct_i)) begin
          state_d = S_HALT;
        end else if (opcode_i == OP_J || opcode_i == OP_JAL) begin
          ctrl_o.pc_we  = 1'b1;
          ctrl_o.pc_src = PC_JUMP;
          ctrl_o.retire = 1'b1;
          if (opcode_i == OP_JAL) begin
            // PC already holds the return address (PC+4)
            ctrl_o.rf_we     = 1'b1;
            ctrl_o.waddr_sel = WA_RA;
            ctrl_o.wdata_sel = WD_PC;
          end
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ctrl_o.aluout_we  = 1'b1;
        ctrl_o.aluout_alu = 1'b1;
        state_d           = S_WB;
        case (opcode_i)
          OP_RTYPE: begin
            ctrl_o.alu_op  = funct_alu_op(funct_i);
            ctrl_o.opb_sel = OPB_REG;
            if (funct_i == FN_JR) begin
              ctrl_o.aluout_we = 1'b0;
              ctrl_o.pc_we     = 1'b1;
              ctrl_o.pc_src    = PC_REG_A;
              ctrl_o.retire    = 1'b1;
              state_d          = S_FETCH;
            end
          end
          OP_ADDI: begin ctrl_o.alu_op = ALU_ADD;   ctrl_o.opb_sel = OPB_SEXT; end
          OP_ANDI: begin ctrl_o.alu_op = ALU_AND;   ctrl_o.opb_sel = OPB_ZEXT; end
          OP_ORI:  begin ctrl_o.alu_op = ALU_OR;    ctrl_o.opb_sel = OPB_ZEXT; end
          OP_LUI:  begin ctrl_o.alu_op = ALU_PASSB; ctrl_o.opb_sel = OPB_LUI;  end
          OP_LW, OP_SW: begin
            ctrl_o.alu_op  = ALU_ADD;
            ctrl_o.opb_sel = OPB_SEXT;
            state_d        = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            // ALUOut already holds the branch target from DECODE
            ctrl_o.aluout_we = 1'b0;
            ctrl_o.pc_we     = (opcode_i == OP_BEQ) ? a_eq_b_i : !a_eq_b_i;
            ctrl_o.pc_src    = PC_ALUOUT;
            ctrl_o.retire    = 1'b1;
            state_d          = S_FETCH;
          end
          default: begin
            ctrl_o.aluout_we = 1'b0;
            state_d          = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        ctrl_o.mem_req     = 1'b1;
        ctrl_o.addr_aluout = 1'b1;
        ctrl_o.mem_we      = (opcode_i == OP_SW);
        if (mem_ready_i) begin
          if (opcode_i == OP_SW) begin
            ctrl_o.retire = 1'b1;
            state_d       = S_FETCH;
          end else begin
            ctrl_o.mdr_we = 1'b1;
            state_d       = S_WB;
          end
        end
      end
      S_WB: begin
        ctrl_o.rf_we     = 1'b1;
        ctrl_o.waddr_sel = (opcode_i == OP_RTYPE) ? WA_RD : WA_RT;
        ctrl_o.wdata_sel = (opcode_i == OP_LW) ? WD_MDR : WD_ALUOUT;
        ctrl_o.retire    = 1'b1;
        state_d          = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/register_file.sv
// 32-entry register file: two asynchronous reads, one synchronous write.
// Register 0 is never written, so it always reads as zero.
module register_file #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [4:0]          raddr1_i,
  input  logic [4:0]          raddr2_i,
  output logic [DATA_LEN-1:0] rdata1_o,
  output logic [DATA_LEN-1:0] rdata2_o
);

  logic [DATA_LEN-1:0] regs_q [32];

  // Clear on reset, otherwise write any register except R0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: datapath registers (PC, IR, A, B, ALUOut,
// MDR), operand/write-back muxes, retire counter, and the shared memory port.
module multi_cycle_cpu #(
  parameter int                DATA_LEN = 32,
  parameter int                ADDR_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int                CNT_LEN  = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  input  logic [DATA_LEN-1:0] mem_rdata,
  input  logic                mem_ready,
  output logic                halted,
  output logic                retire,
  output logic [CNT_LEN-1:0]  instr_count,
  output logic [ADDR_LEN-1:0] pc_out,
  output logic [DATA_LEN-1:0] instr_out
);

  import multi_cycle_cpu_pkg::*;

  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [DATA_LEN-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [DATA_LEN-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
  logic [CNT_LEN-1:0]  cnt_q, cnt_d;

  ctrl_t  ctrl;
  state_e state;

  logic [DATA_LEN-1:0] rf_rdata1, rf_rdata2, rf_wdata, alu_b, alu_y, imm_sext;
  logic [4:0]          rf_waddr;
  logic [15:0]         imm;
  logic [ADDR_LEN-1:0] pc_plus4, branch_tgt, jump_tgt;

  assign imm        = ir_q[15:0];
  assign imm_sext   = {{(DATA_LEN-16){imm[15]}}, imm};
  assign pc_plus4   = pc_q + ADDR_LEN'(4);
  assign branch_tgt = pc_q + ADDR_LEN'(imm_sext << 2);
  assign jump_tgt   = ADDR_LEN'({pc_q[ADDR_LEN-1 -: 4], ir_q[25:0], 2'b00});

  multi_cycle_cpu_ctrl u_ctrl (
    .clk_i       (clk),
    .rst_i       (rst),
    .opcode_i    (ir_q[31:26]),
    .funct_i     (ir_q[5:0]),
    .mem_ready_i (mem_ready),
    .a_eq_b_i    (a_q == b_q),
    .ctrl_o      (ctrl),
    .state_o     (state)
  );

  // ALU B-operand select: register, sign/zero-extended imm, or imm<<16
  always_comb begin
    alu_b = b_q;
    case (ctrl.opb_sel)
      OPB_SEXT: alu_b = imm_sext;
      OPB_ZEXT: alu_b = DATA_LEN'(imm);
      OPB_LUI:  alu_b = DATA_LEN'({imm, 16'h0000});
      default:  alu_b = b_q;
    endcase
  end

  alu #(.DATA_LEN(DATA_LEN)) u_alu (
    .op_i    (ctrl.alu_op),
    .a_i     (a_q),
    .b_i     (alu_b),
    .shamt_i (ir_q[10:6]),
    .y_o     (alu_y)
  );

  // Register-file write address and data select
  always_comb begin
    rf_waddr = ir_q[15:11];
    rf_wdata = aluout_q;
    case (ctrl.waddr_sel)
      WA_RT:   rf_waddr = ir_q[20:16];
      WA_RA:   rf_waddr = 5'd31;
      default: rf_waddr = ir_q[15:11];
    endcase
    case (ctrl.wdata_sel)
      WD_MDR:  rf_wdata = mdr_q;
      WD_PC:   rf_wdata = DATA_LEN'(pc_q);
      default: rf_wdata = aluout_q;
    endcase
  end

  register_file #(.DATA_LEN(DATA_LEN)) u_rf (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (ctrl.rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (ir_q[25:21]),
    .raddr2_i (ir_q[20:16]),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  // Next-state for datapath registers, each gated by its control enable
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    cnt_d    = cnt_q + CNT_LEN'(ctrl.retire);
    if (ctrl.ir_we) ir_d = mem_rdata;
    if (ctrl.pc_we) begin
      case (ctrl.pc_src)
        PC_JUMP:   pc_d = jump_tgt;
        PC_ALUOUT: pc_d = ADDR_LEN'(aluout_q);
        PC_REG_A:  pc_d = ADDR_LEN'(a_q);
        default:   pc_d = pc_plus4;
      endcase
    end
    if (ctrl.ab_we) begin
      a_d = rf_rdata1;
      b_d = rf_rdata2;
    end
    if (ctrl.aluout_we) aluout_d = ctrl.aluout_alu ? alu_y : DATA_LEN'(branch_tgt);
    if (ctrl.mdr_we) mdr_d = mem_rdata;
  end

  // Datapath register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      cnt_q    <= cnt_d;
    end
  end

  // The request is masked while rst is high so no access can start or
  // complete on a reset edge, even if a wait-stated access was pending.
  assign mem_req     = ctrl.mem_req & ~rst;
  assign mem_we      = ctrl.mem_we & ~rst;
  assign mem_addr    = ctrl.addr_aluout ? ADDR_LEN'(aluout_q) : pc_q;
  assign mem_wdata   = b_q;
  assign halted      = (state == S_HALT);
  assign retire      = ctrl.retire;
  assign instr_count = cnt_q;
  assign pc_out      = pc_q;
  assign instr_out   = ir_q;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed tests for multi_cycle_cpu against a wait-stated memory model.
module tb_multi_cycle_cpu;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_JR    = 6'h08;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, halted, retire;
  logic [31:0] mem_addr, mem_wdata, instr_count, pc_out, instr_out;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  multi_cycle_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .halted      (halted),
    .retire      (retire),
    .instr_count (instr_count),
    .pc_out      (pc_out),
    .instr_out   (instr_out)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  // Addresses >= 0x40 take n_waits extra cycles; code below 0x40 is zero-wait.
  logic [31:0] mem [256];
  int n_waits  = 0;
  int wcnt     = 0;
  int wr_count = 0;

  always @(posedge clk) begin
    if (mem_req === 1'b1 && mem_ready === 1'b1 && mem_we === 1'b1) begin
      mem[mem_addr[9:2]] = mem_wdata;
      wr_count++;
    end
    if (rst || mem_req !== 1'b1 || mem_ready === 1'b1) wcnt = 0;
    else wcnt++;
  end

  always @(negedge clk) begin
    mem_ready = (mem_req === 1'b1) && (wcnt >= ((mem_addr >= 32'h40) ? n_waits : 0));
    mem_rdata = mem[mem_addr[9:2]];
  end

  // ---------------- driver tasks ----------------
  int          cyc;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          stab_err;
  logic        prev_pend, prev_we, last_req, last_we;
  logic [31:0] prev_addr, prev_wdata, last_addr;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1;
    got_q.delete();
    exp_q.delete();
    prev_pend = 1'b0;
    stab_err  = 0;
    rst = 1'b0;
  endtask

  // Advance n cycles; sample mid-cycle to log retires and check that a
  // stalled request keeps mem_req/mem_we/mem_addr/mem_wdata stable.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (retire === 1'b1) got_q.push_back(32'(cyc));
      if (prev_pend && (mem_req !== 1'b1 || mem_we !== prev_we ||
                        mem_addr !== prev_addr || mem_wdata !== prev_wdata))
        stab_err++;
      prev_pend  = (mem_req === 1'b1) && (mem_ready !== 1'b1);
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      last_req   = mem_req;
      last_we    = mem_we;
      last_addr  = mem_addr;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_ir got %h want %h", instr_out, 32'h0); end
    checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_retire got %b want 0", retire); end
  endtask

  task automatic test_zero_wait();
    int wr0;
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    mem[1] = enc_i(OP_ADDI, 0, 2, 16'd7);
    mem[2] = enc_r(1, 2, 3, FN_ADD);
    mem[3] = enc_i(OP_SW, 0, 3, 16'h0080);
    n_waits = 0;
    do_reset();
    wr0 = wr_count;
    run(12);
    exp_q = '{32'd4, 32'd8, 32'd12};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL zw_retire_n got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zw_retire_cyc[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL zw_count got %0d want 3", instr_count); end
    checks++; if (pc_out !== 32'h0C) begin errors++; $display("FAIL zw_pc got %h want %h", pc_out, 32'h0C); end
    checks++; if (instr_out !== 32'h0022_1820) begin errors++; $display("FAIL zw_ir got %h want %h", instr_out, 32'h0022_1820); end
    run(4);
    checks++; if (mem[32] !== 32'd12) begin errors++; $display("FAIL zw_sum_r3 got %0d want 12", mem[32]); end
    checks++; if (wr_count - wr0 != 1) begin errors++; $display("FAIL zw_writes got %0d want 1", wr_count - wr0); end
    checks++; if (instr_count !== 32'd4) begin errors++; $display("FAIL zw_count4 got %0d want 4", instr_count); end
  endtask

  task automatic test_mem_wait();
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    mem[1] = enc_i(OP_ADDI, 0, 2, 16'd7);
    mem[2] = enc_r(1, 2, 3, FN_ADD);
    mem[3] = enc_i(OP_SW, 0, 3, 16'h0040);
    mem[4] = enc_i(OP_LW, 0, 4, 16'h0040);
    mem[5] = enc_i(OP_SW, 0, 4, 16'h0044);
    n_waits = 2;
    do_reset();
    run(31);
    exp_q = '{32'd4, 32'd8, 32'd12, 32'd18, 32'd25, 32'd31};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mw_retire_n got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mw_retire_cyc[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (mem[16] !== 32'd12) begin errors++; $display("FAIL mw_sw_data got %0d want 12", mem[16]); end
    checks++; if (mem[17] !== 32'd12) begin errors++; $display("FAIL mw_lw_r4 got %0d want 12", mem[17]); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL mw_stable got %0d want 0", stab_err); end
    checks++; if (instr_count !== 32'd6) begin errors++; $display("FAIL mw_count got %0d want 6", instr_count); end
    checks++; if (pc_out !== 32'h18) begin errors++; $display("FAIL mw_pc got %h want %h", pc_out, 32'h18); end
    n_waits = 0;
  endtask

  task automatic test_branch_jump();
    clear_mem();
    mem[0]  = enc_i(OP_BEQ, 1, 1, 16'd2);        // 0x00 -> 0x0C
    mem[3]  = enc_i(OP_BNE, 1, 1, 16'd2);        // 0x0C -> 0x10
    mem[4]  = {OP_JAL, 26'h000_0040};            // 0x10 -> 0x100, $31=0x14
    mem[64] = enc_r(31, 0, 0, FN_JR);            // 0x100 -> 0x14
    mem[5]  = enc_i(OP_SW, 0, 31, 16'h0080);     // store $31
    mem[6]  = enc_i(OP_BNE, 31, 0, 16'd1);       // 0x18 -> 0x20
    n_waits = 0;
    do_reset();
    run(3);
    checks++; if (pc_out !== 32'h0C) begin errors++; $display("FAIL beq_taken_pc got %h want %h", pc_out, 32'h0C); end
    run(3);
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL bne_fall_pc got %h want %h", pc_out, 32'h10); end
    run(2);
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL jal_pc got %h want %h", pc_out, 32'h100); end
    checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL jal_count got %0d want 3", instr_count); end
    run(3);
    checks++; if (pc_out !== 32'h14) begin errors++; $display("FAIL jr_pc got %h want %h", pc_out, 32'h14); end
    run(4);
    checks++; if (mem[32] !== 32'h14) begin errors++; $display("FAIL jal_link got %h want %h", mem[32], 32'h14); end
    run(3);
    checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL bne_taken_pc got %h want %h", pc_out, 32'h20); end
    exp_q = '{32'd3, 32'd6, 32'd8, 32'd11, 32'd15, 32'd18};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL br_retire_n got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL br_retire_cyc[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_illegal_halt();
    clear_mem();
    mem[0] = 32'hFC00_0000;                      // opcode 0x3F
    n_waits = 0;
    do_reset();
    run(2);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b want 1", halted); end
    run(5);
    checks++; if (last_req !== 1'b0) begin errors++; $display("FAIL halt_mem_req got %b want 0", last_req); end
    checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL halt_pc got %h want %h", pc_out, 32'h4); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL halt_count got %0d want 0", instr_count); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL halt_retire got %0d want 0", got_q.size()); end
    mem[0] = enc_i(OP_ADDI, 0, 6, 16'd3);
    mem[1] = enc_i(OP_SW, 0, 6, 16'h0084);
    mem[2] = enc_r(0, 0, 0, 6'h3F);              // illegal funct
    do_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b want 0", halted); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL halt_rst_pc got %h want %h", pc_out, 32'h0); end
    run(8);
    checks++; if (mem[33] !== 32'd3) begin errors++; $display("FAIL resume_store got %0d want 3", mem[33]); end
    run(2);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL funct_halt got %b want 1", halted); end
  endtask

  task automatic test_reset_mid_mem();
    int wr0;
    clear_mem();
    mem[32] = 32'hDEAD_BEEF;
    mem[0]  = enc_i(OP_SW, 0, 0, 16'h0080);
    n_waits = 5;
    do_reset();
    run(4);
    checks++; if (!(last_req === 1'b1 && last_we === 1'b1 && last_addr === 32'h80)) begin
      errors++; $display("FAIL mid_mem_req got req=%b we=%b addr=%h want 1 1 %h", last_req, last_we, last_addr, 32'h80);
    end
    wr0 = wr_count;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", mem_req); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h want %h", pc_out, 32'h0); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", instr_count); end
    mem[0] = enc_i(OP_LUI, 0, 5, 16'hABCD);
    mem[1] = enc_i(OP_SW, 0, 5, 16'h0088);
    n_waits = 0;
    do_reset();
    checks++; if (wr_count != wr0) begin errors++; $display("FAIL mid_rst_nowrite got %0d want %0d", wr_count, wr0); end
    checks++; if (mem[32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_rst_mem got %h want %h", mem[32], 32'hDEAD_BEEF); end
    run(8);
    checks++; if (mem[34] !== 32'hABCD_0000) begin errors++; $display("FAIL lui_val got %h want %h", mem[34], 32'hABCD_0000); end
    checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL lui_count got %0d want 2", instr_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_mem();
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_branch_jump();
    test_illegal_halt();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing sequence");
    $fatal(1);
  end

endmodule

// File: doc/multi_cycle_cpu.md
Name: multi_cycle_cpu

Overview:
Multi-cycle MIPS-subset core and the successor to the single-cycle CPU top. It splits each instruction into FETCH/DECODE/EXEC/MEM/WB states driven by an FSM. A single shared instruction/data memory port with a ready handshake allows wait-stated memories. It adds jal/jr/bne/lui, a sticky HALT on illegal opcodes, and a retired-instruction counter; the existing alu and register_file are reused.

Parameters:
DATA_LEN, 32, datapath and register width
ADDR_LEN, 32, byte address width; word-aligned accesses only
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_LEN, 32, retired-instruction counter width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
mem_req  output  1  memory access request; held until accepted
mem_we  output  1  write strobe; valid only while mem_req=1
mem_addr  output  ADDR_LEN  byte address (PC in FETCH, ALUOut in MEM)
mem_wdata  output  DATA_LEN  store data (B register)
mem_rdata  input  DATA_LEN  read data; valid in any cycle where mem_ready=1
mem_ready  input  1  access completes on an edge where mem_req=1 and mem_ready=1
halted  output  1  sticky; high in HALT
retire  output  1  one-cycle pulse on the final cycle of each instruction
instr_count  output  CNT_LEN  count of retired instructions; wraps
pc_out  output  ADDR_LEN  current PC (debug)
instr_out  output  DATA_LEN  IR contents (debug)

Behaviour:
- Reset (sync, rst=1 at an edge): PC=RESET_PC, IR=0, state=FETCH, instr_count=0, halted=0, mem_req=0 in the cycle after reset, retire=0. The register file is cleared through its own rst. Reset overrides every state, including HALT and a pending memory access.
- Registers: PC, IR, A, B, ALUOut, MDR. All update only in the states listed below.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. If mem_ready=1: IR<=mem_rdata, PC<=PC+4, next state DECODE. Otherwise stay in FETCH with mem_addr stable.
- DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2).
  - j: PC<={PC[31:28], target, 2'b00}.
  - jal: same PC update, plus R[31]<=PC (PC already holds PC+4).
  - j and jal retire here and go to FETCH.
  - Illegal opcode or funct: go to HALT, no retire.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: ALUOut<=A op B; sll/srl use shamt on B.
  - I-type ALU: ALUOut<=A op ext(imm). addi and lw/sw use sign extension; andi and ori use zero extension; lui gives imm<<16.
  - beq/bne: compare A and B; if taken, PC<=ALUOut. Retire, go to FETCH.
  - jr: PC<=A. Retire, go to FETCH.
  - lw/sw: go to MEM. All others: go to WB.
- MEM: mem_req=1, mem_addr=ALUOut; mem_we=1 for sw.
  - On an edge with mem_ready=1: lw does MDR<=mem_rdata and goes to WB; sw retires and goes to FETCH.
  - While mem_ready=0, the state holds and all mem_* outputs stay stable.
- WB: R[rd or rt]<=ALUOut, or MDR for lw. Retire, go to FETCH.
- Writes to R[0] are discarded by register_file.
- Cycle counts with zero wait states: j/jal 2, beq/bne/jr 3, R/I-ALU/sw 4, lw 5. Each wait cycle adds 1.
- HALT: mem_req=0, halted=1, no register or PC updates, retire=0. Exit only via rst.
- retire is asserted combinationally in the retiring cycle. instr_count increments on that edge and wraps modulo 2^CNT_LEN.
- Unaligned addresses: low two bits are driven as computed; memory ignores them. Alignment is not checked.
- PC arithmetic is modulo 2^ADDR_LEN; PC=0xFFFF_FFFC wraps to 0.

Decomposition:
- defines.v additions: opcode and funct constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR) and state encodings (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT).
- Sub-module multi_cycle_ctrl: FSM plus per-state control decode. The top module holds the datapath registers and muxes and instantiates alu and register_file.

Test Plan:
- Zero-wait program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12; instr_count=3 after 12 cycles; retire pulses at cycles 4, 8, 12.
- Memory with 2 wait states: sw $3,0x40($0) then lw $4,0x40($0) -> write of 12 to 0x40 with mem_addr/mem_wdata stable across wait cycles; $4=12; lw takes 7 cycles.
- Branch: beq $1,$1,+2 -> PC=0x0C after 3 cycles. bne $1,$1,+2 -> falls through to PC+4.
- jal at 0x10 to target 0x100 -> $31=0x14, PC=0x100, 2 cycles; then jr $31 -> PC=0x14.
- Illegal opcode 0x3F -> halted=1 from the cycle after DECODE, mem_req=0; rst pulse -> PC=RESET_PC, halted=0, execution resumes.
- rst asserted during MEM wait on a sw -> no write completes, state=FETCH, instr_count=0; lui $5,0xABCD -> $5=0xABCD0000.
